// File: rtl/cpu7_ifu_ibuf_if.sv
// Purpose: bundles the fetch-side group handshake, the decoder-side head entry
//          and the pipeline control (branch cancel, exu stall) of the
//          instruction buffer into one interface.
// Signals:
//   fetch -> ibuf : fdp_ibuf_valid, fdp_ibuf_pc, fdp_ibuf_count, fdp_ibuf_rdata,
//                   fdp_ibuf_ex, fdp_ibuf_exccode
//   ibuf -> fetch : ibuf_fdp_ready
//   ibuf -> dec   : ibuf_dec_valid, ibuf_dec_inst, ibuf_dec_pc, ibuf_dec_ex,
//                   ibuf_dec_exccode
//   control       : br_cancel (flush), exu_ifu_stall_req (hold head)
// Modports: slave = the buffer, master = its environment.
interface cpu7_ifu_ibuf_if #(
  parameter int GRLEN = 32
);
  logic             br_cancel;
  logic             fdp_ibuf_valid;
  logic [GRLEN-1:0] fdp_ibuf_pc;
  logic [1:0]       fdp_ibuf_count;
  logic [127:0]     fdp_ibuf_rdata;
  logic             fdp_ibuf_ex;
  logic [5:0]       fdp_ibuf_exccode;
  logic             ibuf_fdp_ready;
  logic             ibuf_dec_valid;
  logic [31:0]      ibuf_dec_inst;
  logic [GRLEN-1:0] ibuf_dec_pc;
  logic             ibuf_dec_ex;
  logic [5:0]       ibuf_dec_exccode;
  logic             exu_ifu_stall_req;

  modport slave (
    input  br_cancel, fdp_ibuf_valid, fdp_ibuf_pc, fdp_ibuf_count, fdp_ibuf_rdata,
           fdp_ibuf_ex, fdp_ibuf_exccode, exu_ifu_stall_req,
    output ibuf_fdp_ready, ibuf_dec_valid, ibuf_dec_inst, ibuf_dec_pc, ibuf_dec_ex,
           ibuf_dec_exccode
  );

  modport master (
    output br_cancel, fdp_ibuf_valid, fdp_ibuf_pc, fdp_ibuf_count, fdp_ibuf_rdata,
           fdp_ibuf_ex, fdp_ibuf_exccode, exu_ifu_stall_req,
    input  ibuf_fdp_ready, ibuf_dec_valid, ibuf_dec_inst, ibuf_dec_pc, ibuf_dec_ex,
           ibuf_dec_exccode
  );
endinterface

// File: rtl/cpu7_ifu_ibuf.sv
// Purpose: instruction buffer between the 128-bit group fetch and the
//          one-instruction-per-cycle decoder. Each accepted group is split into
//          1-4 entries {inst, pc, ex, exccode} in a circular queue; the head
//          entry is presented combinationally to the decoder.
// Ports:
//   clock - clock
//   reset - asynchronous active-high reset
//   bus   - cpu7_ifu_ibuf_if.slave: fetch group in, ready out, head entry out,
//           br_cancel flush and exu stall in
// Parameters: DEPTH (power of two, >= 4), GRLEN (PC width).
module cpu7_ifu_ibuf #(
  parameter int DEPTH = 8,
  parameter int GRLEN = 32
) (
  input  logic             clock,
  input  logic             reset,
  cpu7_ifu_ibuf_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    occ_s;
  logic             ready_s;
  logic             push_s;
  logic             pop_s;
  logic             valid_s;
  logic [2:0]       n_s;
  logic [AW-1:0]    head_s;

  logic [31:0]      inst_mem_r [DEPTH];
  logic [GRLEN-1:0] pc_mem_r   [DEPTH];
  logic             ex_mem_r   [DEPTH];
  logic [5:0]       exc_mem_r  [DEPTH];

  // Occupancy, credit and handshake qualification.
  always_comb begin
    occ_s   = wr_ptr_r - rd_ptr_r;
    // Credit is based on registered occupancy only, so a pop in the same
    // cycle never lets a group in early.
    ready_s = (occ_s <= PW'(DEPTH - 4));
    push_s  = bus.fdp_ibuf_valid & ready_s & ~bus.br_cancel;
    // An excepting group collapses to a single entry whatever its count.
    if (bus.fdp_ibuf_ex) begin
      n_s = 3'd1;
    end else begin
      n_s = {1'b0, bus.fdp_ibuf_count} + 3'd1;
    end
    valid_s = (occ_s != PW'(0)) & ~bus.br_cancel;
    pop_s   = valid_s & ~bus.exu_ifu_stall_req;
    head_s  = rd_ptr_r[AW-1:0];
  end

  // Read/write pointers; a flush returns both to zero and blocks push/pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
    end else if (bus.br_cancel) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(n_s);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Entry storage: slot i of an accepted group lands at wr_ptr+i (wrapping).
  // Contents need no reset; outputs are masked while the queue is empty.
  always_ff @(posedge clock) begin
    if (push_s) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < n_s) begin
          inst_mem_r[wr_ptr_r[AW-1:0] + AW'(i)] <=
            bus.fdp_ibuf_ex ? 32'd0 : bus.fdp_ibuf_rdata[32*i +: 32];
          pc_mem_r[wr_ptr_r[AW-1:0] + AW'(i)]   <= bus.fdp_ibuf_pc + GRLEN'(4 * i);
          ex_mem_r[wr_ptr_r[AW-1:0] + AW'(i)]   <= bus.fdp_ibuf_ex;
          exc_mem_r[wr_ptr_r[AW-1:0] + AW'(i)]  <=
            bus.fdp_ibuf_ex ? bus.fdp_ibuf_exccode : 6'd0;
        end
      end
    end
  end

  // Head presentation; data reads zero while the queue is empty.
  always_comb begin
    bus.ibuf_fdp_ready = ready_s;
    bus.ibuf_dec_valid = valid_s;
    if (occ_s != PW'(0)) begin
      bus.ibuf_dec_inst    = inst_mem_r[head_s];
      bus.ibuf_dec_pc      = pc_mem_r[head_s];
      bus.ibuf_dec_ex      = ex_mem_r[head_s];
      bus.ibuf_dec_exccode = exc_mem_r[head_s];
    end else begin
      bus.ibuf_dec_inst    = 32'd0;
      bus.ibuf_dec_pc      = GRLEN'(0);
      bus.ibuf_dec_ex      = 1'b0;
      bus.ibuf_dec_exccode = 6'd0;
    end
  end
endmodule

// File: tb/tb_cpu7_ifu_ibuf.sv
// Self-checking bench for cpu7_ifu_ibuf: a queue-based reference model plus
// directed scenarios with literal expectations, then a randomized phase.
module tb_cpu7_ifu_ibuf;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cpu7_ifu_ibuf_if #(.GRLEN(32)) bus ();

  cpu7_ifu_ibuf #(.DEPTH(DEPTH), .GRLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ex;
    logic [5:0]  exc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] popped_pc[$];
  logic        rec = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of entries, updated on each clock edge.
  always @(posedge clock or posedge reset) begin : model
    int sz;
    if (reset) begin
      mq.delete();
    end else if (bus.br_cancel) begin
      mq.delete();
    end else begin
      sz = mq.size();
      if (sz != 0 && !bus.exu_ifu_stall_req) void'(mq.pop_front());
      if (bus.fdp_ibuf_valid && (DEPTH - sz) >= 4) begin
        if (bus.fdp_ibuf_ex) begin
          mq.push_back('{inst: 32'd0, pc: bus.fdp_ibuf_pc, ex: 1'b1, exc: bus.fdp_ibuf_exccode});
        end else begin
          for (int i = 0; i <= int'(bus.fdp_ibuf_count); i++) begin
            mq.push_back('{inst: bus.fdp_ibuf_rdata[32*i +: 32],
                           pc: bus.fdp_ibuf_pc + 32'(4 * i), ex: 1'b0, exc: 6'd0});
          end
        end
      end
    end
  end

  // Compare process: every cycle, DUT outputs against the model's head.
  always @(negedge clock) begin : cmp
    ent_t h;
    h = '0;
    if (mq.size() != 0) h = mq[0];
    chk("ready", 64'(bus.ibuf_fdp_ready), 64'((DEPTH - mq.size()) >= 4));
    chk("valid", 64'(bus.ibuf_dec_valid), 64'(mq.size() != 0 && !bus.br_cancel));
    chk("inst", 64'(bus.ibuf_dec_inst), 64'(h.inst));
    chk("pc", 64'(bus.ibuf_dec_pc), 64'(h.pc));
    chk("ex", 64'(bus.ibuf_dec_ex), 64'(h.ex));
    chk("exccode", 64'(bus.ibuf_dec_exccode), 64'(h.exc));
    if (rec && bus.ibuf_dec_valid && !bus.exu_ifu_stall_req)
      popped_pc.push_back(bus.ibuf_dec_pc);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fdp_ibuf_valid   = 1'b0;
    bus.fdp_ibuf_pc      = 32'd0;
    bus.fdp_ibuf_count   = 2'd0;
    bus.fdp_ibuf_rdata   = 128'd0;
    bus.fdp_ibuf_ex      = 1'b0;
    bus.fdp_ibuf_exccode = 6'd0;
    bus.br_cancel        = 1'b0;
  endtask

  // Offer one group and hold it until the buffer accepts it (bounded).
  task automatic send(input logic [31:0] pc, input logic [1:0] cnt, input logic [127:0] data,
                      input logic ex, input logic [5:0] exc);
    int   guard;
    logic acc;
    bus.fdp_ibuf_valid   = 1'b1;
    bus.fdp_ibuf_pc      = pc;
    bus.fdp_ibuf_count   = cnt;
    bus.fdp_ibuf_rdata   = data;
    bus.fdp_ibuf_ex      = ex;
    bus.fdp_ibuf_exccode = exc;
    guard = 0;
    do begin
      @(negedge clock);
      acc = bus.ibuf_fdp_ready;
      @(posedge clock);
      #1;
      guard++;
    end while (!acc && guard < 100);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready=0 expected acceptance of pc %0h", pc);
    end
    bus.fdp_ibuf_valid = 1'b0;
  endtask

  logic [31:0] t1w [4];

  initial begin
    idle_inputs();
    bus.exu_ifu_stall_req = 1'b0;
    t1w[0] = 32'haaaa0001; t1w[1] = 32'hbbbb0002;
    t1w[2] = 32'hcccc0003; t1w[3] = 32'hdddd0004;

    // Reset state
    repeat (2) step();
    @(negedge clock);
    chk("rst_valid", 64'(bus.ibuf_dec_valid), 64'd0);
    chk("rst_ready", 64'(bus.ibuf_fdp_ready), 64'd1);
    chk("rst_inst", 64'(bus.ibuf_dec_inst), 64'd0);
    step();
    reset = 1'b0;
    step();

    // 1: one 4-inst group drains A..D on consecutive cycles
    send(32'h1c000000, 2'd3, {t1w[3], t1w[2], t1w[1], t1w[0]}, 1'b0, 6'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("t1_valid", 64'(bus.ibuf_dec_valid), 64'd1);
      chk("t1_inst", 64'(bus.ibuf_dec_inst), 64'(t1w[k]));
      chk("t1_pc", 64'(bus.ibuf_dec_pc), 64'(32'h1c000000 + 32'(4 * k)));
    end
    @(negedge clock);
    chk("t1_empty", 64'(bus.ibuf_dec_valid), 64'd0);
    step();

    // 2: fill while stalled; a held group is not written; drain in order
    bus.exu_ifu_stall_req = 1'b1;
    send(32'h2000, 2'd3, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 6'd0);
    send(32'h2010, 2'd3, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 6'd0);
    bus.fdp_ibuf_valid = 1'b1;
    bus.fdp_ibuf_pc    = 32'h2020;
    bus.fdp_ibuf_count = 2'd3;
    repeat (3) begin
      @(negedge clock);
      chk("t2_ready", 64'(bus.ibuf_fdp_ready), 64'd0);
      chk("t2_head_pc", 64'(bus.ibuf_dec_pc), 64'h2000);
    end
    step();
    bus.fdp_ibuf_valid = 1'b0;
    popped_pc.delete();
    rec = 1'b1;
    bus.exu_ifu_stall_req = 1'b0;
    repeat (10) @(negedge clock);
    rec = 1'b0;
    chk("t2_drain_cnt", 64'(popped_pc.size()), 64'd8);
    for (int k = 0; k < popped_pc.size(); k++)
      chk("t2_drain_pc", 64'(popped_pc[k]), 64'(32'h2000 + 32'(4 * k)));
    step();

    // 3: 20 two-inst groups while popping every cycle; wraps cleanly
    popped_pc.delete();
    rec = 1'b1;
    for (int g = 0; g < 20; g++)
      send(32'h100 + 32'(8 * g), 2'd1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 6'd0);
    repeat (20) step();
    rec = 1'b0;
    chk("t3_cnt", 64'(popped_pc.size()), 64'd40);
    for (int k = 0; k < popped_pc.size(); k++)
      chk("t3_pc", 64'(popped_pc[k]), 64'(32'h100 + 32'(4 * k)));

    // 4: exception group yields exactly one entry, next group follows
    bus.exu_ifu_stall_req = 1'b1;
    send(32'h200, 2'd3, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 6'h08);
    send(32'h210, 2'd0, {96'd0, 32'h12345678}, 1'b0, 6'd0);
    @(negedge clock);
    chk("t4_ex", 64'(bus.ibuf_dec_ex), 64'd1);
    chk("t4_exc", 64'(bus.ibuf_dec_exccode), 64'h08);
    chk("t4_pc", 64'(bus.ibuf_dec_pc), 64'h200);
    chk("t4_inst", 64'(bus.ibuf_dec_inst), 64'd0);
    step();
    bus.exu_ifu_stall_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("t4_next_pc", 64'(bus.ibuf_dec_pc), 64'h210);
    chk("t4_next_ex", 64'(bus.ibuf_dec_ex), 64'd0);
    chk("t4_next_inst", 64'(bus.ibuf_dec_inst), 64'h12345678);
    @(negedge clock);
    chk("t4_empty", 64'(bus.ibuf_dec_valid), 64'd0);
    step();

    // 5: flush with a concurrent push at occupancy 5
    bus.exu_ifu_stall_req = 1'b1;
    send(32'h400, 2'd3, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 6'd0);
    send(32'h410, 2'd0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 6'd0);
    bus.fdp_ibuf_valid = 1'b1;
    bus.fdp_ibuf_pc    = 32'h420;
    bus.fdp_ibuf_count = 2'd3;
    bus.br_cancel      = 1'b1;
    @(negedge clock);
    chk("t5_valid_flush", 64'(bus.ibuf_dec_valid), 64'd0);
    step();
    bus.br_cancel      = 1'b0;
    bus.fdp_ibuf_valid = 1'b0;
    @(negedge clock);
    chk("t5_valid_next", 64'(bus.ibuf_dec_valid), 64'd0);
    chk("t5_ready_next", 64'(bus.ibuf_fdp_ready), 64'd1);
    step();
    bus.exu_ifu_stall_req = 1'b0;
    send(32'h300, 2'd0, {96'd0, 32'hcafe0300}, 1'b0, 6'd0);
    @(negedge clock);
    chk("t5_first_valid", 64'(bus.ibuf_dec_valid), 64'd1);
    chk("t5_first_pc", 64'(bus.ibuf_dec_pc), 64'h300);
    chk("t5_first_inst", 64'(bus.ibuf_dec_inst), 64'hcafe0300);
    step();

    // 6: asynchronous reset mid-drain at occupancy 3
    bus.exu_ifu_stall_req = 1'b1;
    send(32'h500, 2'd3, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 6'd0);
    bus.exu_ifu_stall_req = 1'b0;
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_valid", 64'(bus.ibuf_dec_valid), 64'd0);
    chk("t6_ready", 64'(bus.ibuf_fdp_ready), 64'd1);
    chk("t6_inst", 64'(bus.ibuf_dec_inst), 64'd0);
    chk("t6_pc", 64'(bus.ibuf_dec_pc), 64'd0);
    repeat (2) step();
    reset = 1'b0;
    repeat (5) begin
      @(negedge clock);
      chk("t6_no_stale", 64'(bus.ibuf_dec_valid), 64'd0);
    end
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      bus.fdp_ibuf_valid    = 1'($urandom_range(0, 1));
      bus.fdp_ibuf_pc       = $urandom & 32'hfffffffc;
      bus.fdp_ibuf_count    = 2'($urandom_range(0, 3));
      bus.fdp_ibuf_rdata    = {$urandom, $urandom, $urandom, $urandom};
      bus.fdp_ibuf_ex       = ($urandom_range(0, 7) == 0);
      bus.fdp_ibuf_exccode  = 6'($urandom_range(0, 63));
      bus.exu_ifu_stall_req = ($urandom_range(0, 2) == 0);
      bus.br_cancel         = ($urandom_range(0, 19) == 0);
      step();
    end
    idle_inputs();
    bus.exu_ifu_stall_req = 1'b0;
    repeat (12) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
